// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [31:0] data_t;

  localparam logic  ENABLE  = 1'b1;
  localparam logic  DISABLE = 1'b0;
  localparam logic  VALID   = 1'b1;
  localparam logic  INVALID = 1'b0;
  localparam data_t NULL    = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory request port between instruction fetch and
// the load/store unit. One request is latched at a time, forwarded unchanged,
// and its completion is routed back to the owner. A starvation counter forces
// the non-preferred side through after STARVE_MAX consecutive losses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned D_PRIORITY = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  data_t       if_addr,
  input  logic        if_flush,
  output data_t       if_data_out,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  data_t       d_addr,
  input  data_t       d_data_in,
  input  logic [3:0]  d_be,
  output data_t       d_data_out,
  output logic        d_done,
  output data_t       m_addr,
  output data_t       m_data_in,
  output logic [3:0]  m_be,
  output logic        m_rd,
  output logic        m_wr,
  output logic        m_valid,
  input  data_t       m_data_out,
  input  logic        m_done,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       PREF_IS_D  = (D_PRIORITY != 0);

  arb_state_t state_q, state_d;
  arb_owner_t owner;
  data_t      addr_q, addr_d;
  data_t      wdata_q, wdata_d;
  logic [3:0] be_q, be_d;
  logic       wr_q, wr_d;
  logic       kill_q, kill_d;
  logic       err_q, err_d;
  logic [3:0] starve_q, starve_d;

  logic if_elig, d_elig, pref_elig, oth_elig;
  logic grant_pref, grant_oth, grant_d, grant_if;

  // Next-state: arbitration in IDLE, hold fields while a grant is outstanding.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    wr_d     = wr_q;
    kill_d   = kill_q;
    err_d    = err_q;
    starve_d = starve_q;

    if_elig   = if_req && !if_flush;
    d_elig    = d_req;
    pref_elig = PREF_IS_D ? d_elig  : if_elig;
    oth_elig  = PREF_IS_D ? if_elig : d_elig;
    grant_pref = 1'b0;
    grant_oth  = 1'b0;
    grant_d    = 1'b0;
    grant_if   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m_done) err_d = ENABLE;
        if (pref_elig && oth_elig) begin
          if (starve_q == STARVE_LIM) begin
            grant_oth = 1'b1;
            starve_d  = '0;
          end else begin
            grant_pref = 1'b1;
            starve_d   = 4'(starve_q + 4'd1);
          end
        end else if (pref_elig) begin
          grant_pref = 1'b1;
          starve_d   = '0;
        end else if (oth_elig) begin
          grant_oth = 1'b1;
          starve_d  = '0;
        end else begin
          starve_d = '0;
        end

        grant_d  = PREF_IS_D ? grant_pref : grant_oth;
        grant_if = PREF_IS_D ? grant_oth  : grant_pref;

        if (grant_d) begin
          state_d = GRANT_D;
          addr_d  = d_addr;
          wdata_d = d_data_in;
          be_d    = d_be;
          wr_d    = d_wr;
        end else if (grant_if) begin
          state_d = GRANT_IF;
          addr_d  = if_addr;
          wdata_d = NULL;
          be_d    = '1;
          wr_d    = 1'b0;
        end
      end

      GRANT_IF: begin
        if (if_flush) kill_d = ENABLE;
        if (m_done) begin
          state_d = IDLE;
          kill_d  = DISABLE;
          addr_d  = NULL;
          wdata_d = NULL;
          be_d    = '0;
          wr_d    = 1'b0;
        end
      end

      GRANT_D: begin
        if (m_done) begin
          state_d = IDLE;
          addr_d  = NULL;
          wdata_d = NULL;
          be_d    = '0;
          wr_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and latched command register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= NULL;
      wdata_q  <= NULL;
      be_q     <= '0;
      wr_q     <= 1'b0;
      kill_q   <= DISABLE;
      err_q    <= DISABLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      wr_q     <= wr_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  // Current owner follows directly from the grant state.
  always_comb begin
    unique case (state_q)
      GRANT_IF: owner = OWN_IF;
      GRANT_D:  owner = OWN_D;
      default:  owner = OWN_NONE;
    endcase
  end

  assign m_valid   = (state_q != IDLE) ? VALID : INVALID;
  assign m_addr    = addr_q;
  assign m_data_in = wdata_q;
  assign m_be      = be_q;
  assign m_wr      = wr_q;
  assign m_rd      = m_valid && !wr_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  // A flush landing in the completion cycle must also mask the pulse,
  // since kill_q only reflects flushes from earlier cycles.
  assign if_done     = m_done && (owner == OWN_IF) && !kill_q && !if_flush;
  assign d_done      = m_done && (owner == OWN_D);
  assign if_data_out = m_data_out;
  assign d_data_out  = wr_q ? NULL : m_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with default parameters.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_req, d_wr, m_done;
  logic [31:0] if_addr, d_addr, d_data_in, m_data_out;
  logic [3:0]  d_be;
  logic [31:0] if_data_out, d_data_out, m_addr, m_data_in;
  logic [3:0]  m_be;
  logic        if_done, d_done, m_rd, m_wr, m_valid, busy, err;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  mem_port_arbiter #(.D_PRIORITY(1), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data_out(if_data_out), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
    .d_be(d_be), .d_data_out(d_data_out), .d_done(d_done),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_be(m_be),
    .m_rd(m_rd), .m_wr(m_wr), .m_valid(m_valid),
    .m_data_out(m_data_out), .m_done(m_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance past the next rising edge; inputs are driven after this.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic        exp_d [6];
  logic [31:0] ld_addr;

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_wr = 0; m_done = 0;
    if_addr = '0; d_addr = '0; d_data_in = '0; d_be = '0; m_data_out = '0;
    tick(); tick();
    #1;
    chk("rst_valid", m_valid, 0); chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_addr", m_addr, 0); chk("rst_be", m_be, 0); chk("rst_rdwr", {m_rd, m_wr}, 0);
    rst = 1'b0;

    // Lone fetch
    tick();
    if_req = 1; if_addr = 32'h100;
    #1 chk("f1_idle_valid", m_valid, 0);
    tick();
    #1;
    chk("f1_valid", m_valid, 1); chk("f1_rd", m_rd, 1); chk("f1_wr", m_wr, 0);
    chk("f1_addr", m_addr, 32'h100); chk("f1_be", m_be, 4'hF); chk("f1_wdata", m_data_in, 0);
    chk("f1_busy", busy, 1);
    tick(); tick(); tick();
    m_done = 1; m_data_out = 32'h0000_0013;
    #1;
    chk("f1_if_done", if_done, 1); chk("f1_if_data", if_data_out, 32'h13); chk("f1_d_done", d_done, 0);
    chk("f1_hold_addr", m_addr, 32'h100);
    tick();
    m_done = 0; if_req = 0;
    #1;
    chk("f1_post_busy", busy, 0); chk("f1_post_valid", m_valid, 0); chk("f1_post_if_done", if_done, 0);

    // Collision: data write wins by default, fetch follows
    tick();
    if_req = 1; if_addr = 32'h104;
    d_req = 1; d_wr = 1; d_addr = 32'h200; d_data_in = 32'hDEADBEEF; d_be = 4'h3;
    tick();
    #1;
    chk("c_wr", m_wr, 1); chk("c_rd", m_rd, 0); chk("c_be", m_be, 4'h3);
    chk("c_addr", m_addr, 32'h200); chk("c_wdata", m_data_in, 32'hDEADBEEF);
    tick();
    m_done = 1; m_data_out = 32'hCAFEF00D;
    #1;
    chk("c_d_done", d_done, 1); chk("c_d_data_wr", d_data_out, 0); chk("c_if_done", if_done, 0);
    tick();
    m_done = 0; d_req = 0;
    #1 chk("c_gap_busy", busy, 0);
    tick();
    #1;
    chk("c_f_addr", m_addr, 32'h104); chk("c_f_rd", m_rd, 1); chk("c_f_be", m_be, 4'hF);
    chk("c_f_wdata", m_data_in, 0);
    tick();
    m_done = 1; m_data_out = 32'h55;
    #1;
    chk("c_f_done", if_done, 1); chk("c_f_ddone", d_done, 0);
    tick();
    m_done = 0; if_req = 0;

    // Starvation: five loads vs a waiting fetch -> D D D D IF D
    exp_d[0] = 1; exp_d[1] = 1; exp_d[2] = 1; exp_d[3] = 1; exp_d[4] = 0; exp_d[5] = 1;
    ld_addr = 32'h300;
    if_req = 1; if_addr = 32'h108;
    d_req = 1; d_wr = 0; d_addr = ld_addr; d_be = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1 chk($sformatf("s%0d_addr", i), m_addr, exp_d[i] ? ld_addr : 32'h108);
      tick();
      m_done = 1; m_data_out = 32'hA000 + 32'(i);
      #1;
      chk($sformatf("s%0d_d_done", i), d_done, exp_d[i]);
      chk($sformatf("s%0d_if_done", i), if_done, !exp_d[i]);
      if (exp_d[i]) chk($sformatf("s%0d_d_data", i), d_data_out, 32'hA000 + 32'(i));
      tick();
      m_done = 0;
      if (exp_d[i]) begin
        ld_addr = ld_addr + 32'h4; d_addr = ld_addr;
      end else begin
        if_req = 0;
      end
      if (i == 5) d_req = 0;
      #1 chk($sformatf("s%0d_gap_busy", i), busy, 0);
    end

    // Flush in IDLE suppresses the fetch request
    tick();
    if_req = 1; if_addr = 32'h140; if_flush = 1;
    tick();
    if_flush = 0;
    #1 chk("fi_busy", busy, 0);
    tick();
    #1 chk("fi_grant_addr", m_addr, 32'h140);

    // Flush in flight: bus completes, if_done masked, next fetch normal
    if_flush = 1; if_addr = 32'h180;
    tick();
    if_flush = 0;
    tick();
    m_done = 1; m_data_out = 32'hBAD;
    #1;
    chk("ff_if_done", if_done, 0); chk("ff_d_done", d_done, 0);
    tick();
    m_done = 0;
    #1 chk("ff_busy", busy, 0);
    tick();
    #1;
    chk("ff_next_addr", m_addr, 32'h180); chk("ff_next_busy", busy, 1);
    tick();
    m_done = 1; m_data_out = 32'h77;
    #1;
    chk("ff_next_done", if_done, 1); chk("ff_next_data", if_data_out, 32'h77);
    tick();
    m_done = 0; if_addr = 32'h1C0;
    tick();
    #1 chk("fs_grant_addr", m_addr, 32'h1C0);
    // Flush coincident with m_done
    if_flush = 1; m_done = 1;
    #1 chk("fs_if_done", if_done, 0);
    tick();
    if_flush = 0; m_done = 0; if_req = 0;
    #1 chk("fs_busy", busy, 0);

    // Reset during a write
    tick();
    d_req = 1; d_wr = 1; d_addr = 32'h400; d_data_in = 32'h12345678; d_be = 4'hC;
    tick();
    #1 chk("rw_wr", m_wr, 1);
    rst = 1; d_req = 0;
    tick();
    #1;
    chk("rw_valid", m_valid, 0); chk("rw_wr0", m_wr, 0); chk("rw_addr", m_addr, 0);
    chk("rw_be", m_be, 0); chk("rw_wdata", m_data_in, 0); chk("rw_busy", busy, 0);
    chk("rw_err", err, 0); chk("rw_d_done", d_done, 0);
    rst = 0;

    // Spurious m_done in IDLE sets sticky err
    tick();
    m_done = 1;
    #1;
    chk("sp_d_done", d_done, 0); chk("sp_if_done", if_done, 0); chk("sp_err_pre", err, 0);
    tick();
    m_done = 0;
    #1 chk("sp_err", err, 1);
    tick(); tick();
    #1 chk("sp_err_sticky", err, 1);
    rst = 1;
    tick();
    #1 chk("sp_err_rst", err, 0);
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
